// File: rtl/li_credit_sender.sv
`default_nettype none
// ============================================================================
// Module   : li_credit_sender
// Brief    : Credit-based latency-insensitive link transmitter. Forwards
//            upstream ready/valid words as single-cycle link pulses while
//            receiver credits remain.
// Revision : 1.0 - initial release
// ============================================================================
module li_credit_sender #(
    parameter int DATA_WIDTH   = 17,
    parameter int N_CREDITS    = 16,
    parameter int CREDIT_WIDTH = $clog2(N_CREDITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    input  logic                    i_credit,
    output logic [CREDIT_WIDTH-1:0] o_credits,
    output logic                    o_idle,
    output logic                    o_credit_error
);

    localparam logic [CREDIT_WIDTH-1:0] c_full_credits = CREDIT_WIDTH'(N_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] c_one          = CREDIT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0] r_credits;
    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_credit_error;
    logic                    w_accept;

    // Ready is gated by reset so nothing is accepted while reset is asserted.
    assign o_ready  = reset && (r_credits != '0);
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_credits      <= c_full_credits;
            r_valid        <= 1'b0;
            r_data         <= '0;
            r_credit_error <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= i_data;
            end
            // A send and a return in the same cycle cancel out.
            case ({w_accept, i_credit})
                2'b10: r_credits <= r_credits - c_one;
                2'b01: begin
                    if (r_credits == c_full_credits) begin
                        r_credit_error <= 1'b1;
                    end else begin
                        r_credits <= r_credits + c_one;
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign o_valid        = r_valid;
    assign o_data         = r_data;
    assign o_credits      = r_credits;
    assign o_idle         = (r_credits == c_full_credits);
    assign o_credit_error = r_credit_error;

endmodule
`default_nettype wire

// File: tb/tb_li_credit_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_li_credit_sender
// Brief    : Scoreboard bench for li_credit_sender with directed and random
//            stimulus against an arithmetic credit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_li_credit_sender;

    localparam int DW = 17;
    localparam int NC = 16;
    localparam int CW = $clog2(NC + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_credit;
    logic [CW-1:0] o_credits;
    logic          o_idle;
    logic          o_credit_error;

    li_credit_sender #(
        .DATA_WIDTH (DW),
        .N_CREDITS  (NC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_credit       (i_credit),
        .o_credits      (o_credits),
        .o_idle         (o_idle),
        .o_credit_error (o_credit_error)
    );

    always #5 clock = ~clock;

    // Reference model state
    int            m_credits;
    bit            m_err;
    bit            m_last_rst;
    bit            exp_valid;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] cur_data;
    bit            rand_mode;
    bit            mon_en;
    int            n_checks;
    int            n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One link cycle: drive after the falling edge, check registered state,
    // then advance the model at the rising edge.
    task automatic cyc(input bit rst_n, input bit v, input bit cr);
        bit acc;
        @(negedge clock);
        reset    = rst_n;
        i_valid  = v;
        i_data   = cur_data;
        i_credit = cr;
        #1;
        chk("ready", {31'b0, o_ready}, {31'b0, (rst_n && m_credits != 0)});
        chk("credits", 32'(o_credits), m_credits);
        chk("idle", {31'b0, o_idle}, {31'b0, (m_credits == NC)});
        chk("credit_error", {31'b0, o_credit_error}, {31'b0, m_err});
        if (m_last_rst) chk("data_after_reset", 32'(o_data), 32'd0);
        acc = rst_n && v && (m_credits != 0);
        @(posedge clock);
        m_last_rst = !rst_n;
        if (!rst_n) begin
            m_credits = NC;
            m_err     = 1'b0;
            exp_valid = 1'b0;
            sb_q.delete();
        end else begin
            exp_valid = acc;
            if (acc) sb_q.push_back(cur_data);
            m_credits = m_credits + int'(cr) - int'(acc);
            if (m_credits > NC) begin
                m_credits = NC;
                m_err     = 1'b1;
            end
        end
        if (acc) cur_data = rand_mode ? DW'($urandom) : cur_data + 1'b1;
    endtask

    // Monitor: every link pulse must match the oldest accepted word.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                chk("valid", {31'b0, o_valid}, {31'b0, exp_valid});
                if (o_valid === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected no word at %0t", o_data, $time);
                    end else begin
                        chk("data", 32'(o_data), 32'(sb_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        i_valid    = 1'b0;
        i_data     = '0;
        i_credit   = 1'b0;
        cur_data   = DW'(1);
        rand_mode  = 1'b0;
        m_credits  = NC;
        m_err      = 1'b0;
        exp_valid  = 1'b0;
        m_last_rst = 1'b1;
        mon_en     = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        @(posedge clock);
        mon_en = 1'b1;

        repeat (3) cyc(0, 1, 0);                // reset held with i_valid high
        repeat (20) cyc(1, 1, 0);               // exhaust all credits, word 17 held
        cyc(1, 1, 1);                           // single credit at zero
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 1);                // credits back to 5
        repeat (20) cyc(1, 1, 1);               // simultaneous send and return
        repeat (11) cyc(1, 0, 1);               // credits back to full
        cyc(1, 0, 1);                           // overflow return
        repeat (16) cyc(1, 1, 1);               // error flag must persist
        cyc(1, 0, 0);
        cyc(0, 0, 0);                           // reset clears error
        repeat (9) cyc(1, 1, 0);                // credits down to 7
        cyc(0, 1, 0);                           // reset mid-burst
        repeat (4) cyc(1, 1, 0);

        rand_mode = 1'b1;
        cur_data  = DW'($urandom);
        repeat (400) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 3) != 0,
                (m_credits < NC) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0));
        end
        repeat (3) cyc(1, 0, 0);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words outstanding expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
